// File: rtl/day_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : day_cycle_sequencer
// Description : 24-hour day clock with night/sunrise/day/sunset phases.
//               Ramps red/blue LED intensities one level per fade strobe
//               during sunrise and sunset; shows the hour as two BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module day_cycle_sequencer #(
  parameter int HOURS_PER_DAY = 24,
  parameter int SUNRISE_HOUR  = 6,
  parameter int SUNSET_HOUR   = 18,
  parameter int FADE_CYCLES   = 3125000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       hour_tick,
  input  logic       enable,
  input  logic       hour_load,
  input  logic [4:0] hour_set,
  output logic [3:0] red_level,
  output logic [3:0] blue_level,
  output logic [7:0] hour_bcd,
  output logic [1:0] phase,
  output logic       day_done
);

  typedef enum logic [1:0] {
    NIGHT   = 2'd0,
    SUNRISE = 2'd1,
    DAY     = 2'd2,
    SUNSET  = 2'd3
  } phase_t;

  localparam int CNT_W = (FADE_CYCLES > 2) ? $clog2(FADE_CYCLES) : 1;

  localparam logic [4:0]       c_last_hour  = 5'(HOURS_PER_DAY - 1);
  localparam logic [5:0]       c_hours      = 6'(HOURS_PER_DAY);
  localparam logic [4:0]       c_sunrise    = 5'(SUNRISE_HOUR);
  localparam logic [4:0]       c_sunset     = 5'(SUNSET_HOUR);
  localparam logic [CNT_W-1:0] c_fade_last  = CNT_W'(FADE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam logic [3:0]       c_night_red  = 4'd0;
  localparam logic [3:0]       c_night_blue = 4'd3;
  localparam logic [3:0]       c_day_red    = 4'd15;
  localparam logic [3:0]       c_day_blue   = 4'd15;

  phase_t           r_state;
  logic [4:0]       r_hour;
  logic [3:0]       r_red;
  logic [3:0]       r_blue;
  logic             r_day_done;
  logic [CNT_W-1:0] r_fade_cnt;

  logic [4:0] w_load_hour;
  logic       w_load_is_day;
  logic       w_tick;
  logic       w_wrap;
  logic [4:0] w_hour_next;
  logic       w_enter_sunrise;
  logic       w_enter_sunset;
  logic       w_strobe;
  logic [3:0] w_tgt_red;
  logic [3:0] w_tgt_blue;
  logic [3:0] w_red_step;
  logic [3:0] w_blue_step;
  logic       w_at_target;
  logic [1:0] w_tens;
  logic [3:0] w_ones;

  // Move a level one step toward its target, never past it.
  function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
    if (cur < tgt)      return cur + 4'd1;
    else if (cur > tgt) return cur - 4'd1;
    else                return cur;
  endfunction

  // Next-hour selection, phase-change triggers and the candidate ramp step.
  always_comb begin
    w_load_hour     = ({1'b0, hour_set} >= c_hours) ? 5'd0 : hour_set;
    w_load_is_day   = (w_load_hour >= c_sunrise) && (w_load_hour < c_sunset);
    // A load wins over a tick, so a simultaneous tick never advances or wraps.
    w_tick          = hour_tick && enable && !hour_load;
    w_wrap          = w_tick && (r_hour == c_last_hour);
    w_hour_next     = r_hour;
    if (hour_load)   w_hour_next = w_load_hour;
    else if (w_wrap) w_hour_next = 5'd0;
    else if (w_tick) w_hour_next = r_hour + 5'd1;
    w_enter_sunrise = w_tick && (w_hour_next == c_sunrise);
    w_enter_sunset  = w_tick && (w_hour_next == c_sunset);
    w_strobe        = ((r_state == SUNRISE) || (r_state == SUNSET)) &&
                      (r_fade_cnt == c_fade_last);
    w_tgt_red       = (r_state == SUNRISE) ? c_day_red  : c_night_red;
    w_tgt_blue      = (r_state == SUNRISE) ? c_day_blue : c_night_blue;
    w_red_step      = step_toward(r_red,  w_tgt_red);
    w_blue_step     = step_toward(r_blue, w_tgt_blue);
    // The ramp ends on the strobe that lands both levels on their targets.
    w_at_target     = (w_red_step == w_tgt_red) && (w_blue_step == w_tgt_blue);
  end

  // Hour register, phase FSM, fade counter and LED levels.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_hour     <= 5'd0;
      r_state    <= NIGHT;
      r_red      <= c_night_red;
      r_blue     <= c_night_blue;
      r_day_done <= 1'b0;
      r_fade_cnt <= '0;
    end else begin
      r_hour     <= w_hour_next;
      r_day_done <= w_wrap;
      if (hour_load) begin
        r_fade_cnt <= '0;
        if (w_load_is_day) begin
          r_state <= DAY;
          r_red   <= c_day_red;
          r_blue  <= c_day_blue;
        end else begin
          r_state <= NIGHT;
          r_red   <= c_night_red;
          r_blue  <= c_night_blue;
        end
      end else begin
        case (r_state)
          NIGHT: begin
            r_fade_cnt <= '0;
            if (w_enter_sunrise) r_state <= SUNRISE;
          end
          DAY: begin
            r_fade_cnt <= '0;
            if (w_enter_sunset) r_state <= SUNSET;
          end
          default: begin
            // Reaching the opposite ramp hour reverses the ramp from the
            // current levels; that edge takes no step of its own.
            if ((r_state == SUNRISE) && w_enter_sunset) begin
              r_state    <= SUNSET;
              r_fade_cnt <= '0;
            end else if ((r_state == SUNSET) && w_enter_sunrise) begin
              r_state    <= SUNRISE;
              r_fade_cnt <= '0;
            end else if (w_strobe) begin
              r_fade_cnt <= '0;
              r_red      <= w_red_step;
              r_blue     <= w_blue_step;
              if (w_at_target) r_state <= (r_state == SUNRISE) ? DAY : NIGHT;
            end else begin
              r_fade_cnt <= r_fade_cnt + c_cnt_one;
            end
          end
        endcase
      end
    end
  end

  // Hour to BCD. ones = hour - 10*tens, done in 4 bits since the result is
  // below 10: subtracting 10, 20, 30 is subtracting 10, 4, 14 modulo 16.
  always_comb begin
    w_tens = 2'd0;
    w_ones = r_hour[3:0];
    if (r_hour >= 5'd30) begin
      w_tens = 2'd3;
      w_ones = r_hour[3:0] - 4'd14;
    end else if (r_hour >= 5'd20) begin
      w_tens = 2'd2;
      w_ones = r_hour[3:0] - 4'd4;
    end else if (r_hour >= 5'd10) begin
      w_tens = 2'd1;
      w_ones = r_hour[3:0] - 4'd10;
    end
  end

  assign hour_bcd   = {2'b00, w_tens, w_ones};
  assign red_level  = r_red;
  assign blue_level = r_blue;
  assign phase      = r_state;
  assign day_done   = r_day_done;

endmodule
`default_nettype wire

// File: tb/tb_day_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_day_cycle_sequencer
// Description : Self-checking bench for day_cycle_sequencer: an abstract
//               per-cycle model plus hand-computed checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_day_cycle_sequencer;

  localparam int HPD  = 24;
  localparam int SR   = 6;
  localparam int SS   = 18;
  localparam int FADE = 4;

  logic       CLOCK_50  = 1'b0;
  logic       reset     = 1'b0;
  logic       hour_tick = 1'b0;
  logic       enable    = 1'b0;
  logic       hour_load = 1'b0;
  logic [4:0] hour_set  = 5'd0;
  logic [3:0] red_level;
  logic [3:0] blue_level;
  logic [7:0] hour_bcd;
  logic [1:0] phase;
  logic       day_done;

  int errors = 0;
  int checks = 0;

  // Model state: plain integers describing the simulated day.
  int m_hour, m_phase, m_red, m_blue, m_dd, m_age;

  // 50 MHz-style free-running clock.
  always #5 CLOCK_50 = ~CLOCK_50;

  day_cycle_sequencer #(
    .HOURS_PER_DAY(HPD),
    .SUNRISE_HOUR (SR),
    .SUNSET_HOUR  (SS),
    .FADE_CYCLES  (FADE)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .hour_tick (hour_tick),
    .enable    (enable),
    .hour_load (hour_load),
    .hour_set  (hour_set),
    .red_level (red_level),
    .blue_level(blue_level),
    .hour_bcd  (hour_bcd),
    .phase     (phase),
    .day_done  (day_done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  task automatic model_reset();
    m_hour = 0; m_phase = 0; m_red = 0; m_blue = 3; m_dd = 0; m_age = 0;
  endtask

  // One rising edge of the day, from the rules: load snaps, ticks advance the
  // clock, ramp hours switch phase, and every FADE cycles a ramp steps.
  task automatic model_step(input bit tick, input bit en, input bit load, input int set);
    bit adv;
    int tr, tb;
    m_dd = 0;
    if (load) begin
      m_hour  = (set < HPD) ? set : 0;
      m_age   = 0;
      if (m_hour >= SR && m_hour < SS) begin
        m_phase = 2; m_red = 15; m_blue = 15;
      end else begin
        m_phase = 0; m_red = 0; m_blue = 3;
      end
    end else begin
      adv = tick && en;
      if (adv) begin
        m_hour = (m_hour + 1) % HPD;
        if (m_hour == 0) m_dd = 1;
      end
      if (adv && m_hour == SR && (m_phase == 0 || m_phase == 3)) begin
        m_phase = 1; m_age = 0;
      end else if (adv && m_hour == SS && (m_phase == 2 || m_phase == 1)) begin
        m_phase = 3; m_age = 0;
      end else if (m_phase == 1 || m_phase == 3) begin
        m_age++;
        if (m_age == FADE) begin
          m_age  = 0;
          tr     = (m_phase == 1) ? 15 : 0;
          tb     = (m_phase == 1) ? 15 : 3;
          m_red  = toward(m_red, tr);
          m_blue = toward(m_blue, tb);
          if (m_red == tr && m_blue == tb) m_phase = (m_phase == 1) ? 2 : 0;
        end
      end
    end
  endtask

  // Advance the model on every edge and compare all outputs just after it.
  always @(posedge CLOCK_50) begin
    if (!reset) model_reset();
    else        model_step(hour_tick, enable, hour_load, int'(hour_set));
    #1;
    if (reset) begin
      check("model hour_bcd",   int'(hour_bcd),   ((m_hour / 10) << 4) | (m_hour % 10));
      check("model phase",      int'(phase),      m_phase);
      check("model red_level",  int'(red_level),  m_red);
      check("model blue_level", int'(blue_level), m_blue);
      check("model day_done",   int'(day_done),   m_dd);
    end
  end

  task automatic drive(input logic t, input logic e, input logic l, input logic [4:0] s);
    @(negedge CLOCK_50);
    hour_tick = t; enable = e; hour_load = l; hour_set = s;
    @(posedge CLOCK_50);
    #2;
  endtask

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles.
    reset = 1'b0; enable = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #2;
    check("reset hour_bcd", int'(hour_bcd),   8'h00);
    check("reset phase",    int'(phase),      0);
    check("reset red",      int'(red_level),  0);
    check("reset blue",     int'(blue_level), 3);
    check("reset day_done", int'(day_done),   0);
    @(negedge CLOCK_50);
    reset = 1'b1;

    // Sunrise: six ticks reach hour 6 and start the ramp on that edge.
    repeat (6) drive(1'b1, 1'b1, 1'b0, 5'd0);
    check("sunrise entry bcd",   int'(hour_bcd), 8'h06);
    check("sunrise entry phase", int'(phase),    1);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 5'd0);
    check("first step red",  int'(red_level),  1);
    check("first step blue", int'(blue_level), 4);
    repeat (44) drive(1'b0, 1'b1, 1'b0, 5'd0);
    check("cycle48 blue",  int'(blue_level), 15);
    check("cycle48 red",   int'(red_level),  12);
    check("cycle48 phase", int'(phase),      1);
    repeat (12) drive(1'b0, 1'b1, 1'b0, 5'd0);
    check("cycle60 red",   int'(red_level), 15);
    check("cycle60 phase", int'(phase),     2);

    // Day wrap.
    drive(1'b0, 1'b1, 1'b1, 5'd23);
    check("load23 bcd",   int'(hour_bcd), 8'h23);
    check("load23 phase", int'(phase),    0);
    drive(1'b1, 1'b1, 1'b0, 5'd0);
    check("wrap bcd",      int'(hour_bcd), 8'h00);
    check("wrap day_done", int'(day_done), 1);
    check("wrap phase",    int'(phase),    0);
    drive(1'b0, 1'b1, 1'b0, 5'd0);
    check("wrap day_done drop", int'(day_done), 0);

    // Load snap, in-range and out-of-range.
    drive(1'b0, 1'b1, 1'b1, 5'd12);
    check("load12 phase", int'(phase),      2);
    check("load12 red",   int'(red_level),  15);
    check("load12 blue",  int'(blue_level), 15);
    check("load12 bcd",   int'(hour_bcd),   8'h12);
    drive(1'b0, 1'b1, 1'b1, 5'd30);
    check("load30 bcd",   int'(hour_bcd),   8'h00);
    check("load30 phase", int'(phase),      0);
    check("load30 red",   int'(red_level),  0);
    check("load30 blue",  int'(blue_level), 3);

    // Load and tick together at hour 23: only the load happens.
    drive(1'b0, 1'b1, 1'b1, 5'd23);
    drive(1'b1, 1'b1, 1'b1, 5'd5);
    check("both bcd",      int'(hour_bcd), 8'h05);
    check("both day_done", int'(day_done), 0);
    check("both phase",    int'(phase),    0);

    // Pause: start a sunrise, then five ticks with enable low.
    drive(1'b1, 1'b1, 1'b0, 5'd0);
    repeat (5) drive(1'b1, 1'b0, 1'b0, 5'd0);
    check("pause bcd",  int'(hour_bcd),   8'h06);
    check("pause red",  int'(red_level),  1);
    check("pause blue", int'(blue_level), 4);

    // Interrupted sunrise: tick straight through to hour 18.
    repeat (12) drive(1'b1, 1'b1, 1'b0, 5'd0);
    check("interrupt phase", int'(phase),      3);
    check("interrupt red",   int'(red_level),  4);
    check("interrupt blue",  int'(blue_level), 7);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 5'd0);
    check("sunset step red",  int'(red_level),  3);
    check("sunset step blue", int'(blue_level), 6);
    repeat (12) drive(1'b0, 1'b1, 1'b0, 5'd0);
    check("sunset done phase", int'(phase),      0);
    check("sunset done red",   int'(red_level),  0);
    check("sunset done blue",  int'(blue_level), 3);

    // Interrupted sunset: from 18 tick round the wrap to 6.
    drive(1'b0, 1'b1, 1'b1, 5'd17);
    drive(1'b1, 1'b1, 1'b0, 5'd0);
    repeat (12) drive(1'b1, 1'b1, 1'b0, 5'd0);
    check("reverse phase", int'(phase),      1);
    check("reverse red",   int'(red_level),  13);
    check("reverse blue",  int'(blue_level), 13);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 5'd0);

    // Asynchronous reset mid-ramp, away from any clock edge.
    #3;
    reset = 1'b0;
    #1;
    check("async hour_bcd", int'(hour_bcd),   8'h00);
    check("async phase",    int'(phase),      0);
    check("async red",      int'(red_level),  0);
    check("async blue",     int'(blue_level), 3);
    check("async day_done", int'(day_done),   0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 5'd0);
    check("post reset bcd", int'(hour_bcd), 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
